// File: rtl/hangman_core.sv
`default_nettype none
// ------------------------------------------------------------------------------------------
// hangman_core - hangman game engine, one letter position checked per cycle. Rev 1.0
// Option: define HANGMAN_REPEAT_PENALTY_EN to count a guess that reveals nothing new as a miss.
// ------------------------------------------------------------------------------------------
module hangman_core #(
  parameter int WORD_LEN  = 5,
  parameter int CHAR_W    = 8,
  parameter int MAX_TRIES = 7,
  parameter int IDX_W     = 6
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start_i,
  input  logic                       guess_valid_i,
  input  logic [CHAR_W-1:0]          guess_char_i,
  output logic                       guess_ready_o,
  output logic [IDX_W-1:0]           word_idx_o,
  input  logic [WORD_LEN*CHAR_W-1:0] word_data_i,
  output logic [WORD_LEN-1:0]        revealed_o,
  output logic [3:0]                 tries_o,
  output logic                       win_o,
  output logic                       lose_o,
  output logic                       busy_o
);

  localparam int               POS_W     = $clog2(WORD_LEN);
  localparam logic [POS_W-1:0] LAST_POS  = POS_W'(WORD_LEN - 1);
  localparam logic [3:0]       TRY_MAX   = 4'(MAX_TRIES);
  localparam logic [15:0]      LFSR_SEED = 16'h0001;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_GUESS  = 3'd2,
    S_CHECK  = 3'd3,
    S_UPDATE = 3'd4,
    S_WIN    = 3'd5,
    S_LOSE   = 3'd6
  } state_e;

  state_e                     state_q, state_d;
  logic [15:0]                lfsr_q, lfsr_d;
  logic [WORD_LEN*CHAR_W-1:0] word_q, word_d;
  logic [CHAR_W-1:0]          guess_q, guess_d;
  logic [POS_W-1:0]           pos_q, pos_d;
  logic [WORD_LEN-1:0]        rev_q, rev_d;
  logic [3:0]                 tries_q, tries_d;
  logic                       hit_q, hit_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       ready_q, ready_d;
  logic                       busy_q, busy_d;
  logic                       win_q, win_d;
  logic                       lose_q, lose_d;
  logic                       publish_q, publish_d;
  logic [WORD_LEN-1:0]        rev_out_q, rev_out_d;
  logic [3:0]                 tries_out_q, tries_out_d;

  logic [CHAR_W-1:0] word_chars [WORD_LEN];
  logic              pos_match;
  logic [3:0]        tries_miss;
  logic [3:0]        tries_upd;

  for (genvar g = 0; g < WORD_LEN; g++) begin : g_chars
    assign word_chars[g] = word_q[g*CHAR_W +: CHAR_W];
  end

  assign pos_match  = (word_chars[pos_q] == guess_q);
  assign tries_miss = (tries_q >= TRY_MAX) ? tries_q : tries_q + 4'd1;
  assign tries_upd  = hit_q ? tries_q : tries_miss;

  function automatic logic is_busy(input state_e s);
    return (s == S_LOAD) || (s == S_CHECK) || (s == S_UPDATE);
  endfunction

  always_comb begin
    state_d = state_q;
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    word_d  = word_q;
    guess_d = guess_q;
    pos_d   = pos_q;
    rev_d   = rev_q;
    tries_d = tries_q;
    hit_d   = hit_q;
    idx_d   = idx_q;

    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start_i) begin
          state_d = S_LOAD;
          idx_d   = lfsr_q[IDX_W-1:0];
          rev_d   = '0;
          tries_d = 4'd0;
        end
      end
      S_LOAD: begin
        word_d  = word_data_i;
        state_d = S_GUESS;
      end
      S_GUESS: begin
        if (guess_valid_i && ready_q) begin
          guess_d = guess_char_i;
          hit_d   = 1'b0;
          pos_d   = '0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (pos_match) begin
          rev_d[pos_q] = 1'b1;
`ifdef HANGMAN_REPEAT_PENALTY_EN
          if (!rev_q[pos_q]) hit_d = 1'b1;
`else
          hit_d = 1'b1;
`endif
        end
        if (pos_q == LAST_POS) state_d = S_UPDATE;
        else                   pos_d   = pos_q + POS_W'(1);
      end
      S_UPDATE: begin
        tries_d = tries_upd;
        // A full reveal wins even if this same guess used up the last try.
        if (&rev_q)                    state_d = S_WIN;
        else if (tries_upd == TRY_MAX) state_d = S_LOSE;
        else                           state_d = S_GUESS;
      end
      default: state_d = S_IDLE;
    endcase

    // Results are published one cycle after UPDATE; ready and win/lose wait for the same edge.
    ready_d     = (state_q == S_GUESS) && (state_d == S_GUESS);
    busy_d      = is_busy(state_q) || is_busy(state_d);
    win_d       = (state_q == S_WIN) && (state_d == S_WIN);
    lose_d      = (state_q == S_LOSE) && (state_d == S_LOSE);
    publish_d   = (state_q == S_UPDATE);
    rev_out_d   = (publish_q || state_q == S_LOAD) ? rev_q : rev_out_q;
    tries_out_d = (publish_q || state_q == S_LOAD) ? tries_q : tries_out_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      word_q      <= '0;
      guess_q     <= '0;
      pos_q       <= '0;
      rev_q       <= '0;
      tries_q     <= 4'd0;
      hit_q       <= 1'b0;
      idx_q       <= '0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      win_q       <= 1'b0;
      lose_q      <= 1'b0;
      publish_q   <= 1'b0;
      rev_out_q   <= '0;
      tries_out_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      word_q      <= word_d;
      guess_q     <= guess_d;
      pos_q       <= pos_d;
      rev_q       <= rev_d;
      tries_q     <= tries_d;
      hit_q       <= hit_d;
      idx_q       <= idx_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      win_q       <= win_d;
      lose_q      <= lose_d;
      publish_q   <= publish_d;
      rev_out_q   <= rev_out_d;
      tries_out_q <= tries_out_d;
    end
  end

  assign guess_ready_o = ready_q;
  assign word_idx_o    = idx_q;
  assign revealed_o    = rev_out_q;
  assign tries_o       = tries_out_q;
  assign win_o         = win_q;
  assign lose_o        = lose_q;
  assign busy_o        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_hangman_core.sv
`default_nettype none
// tb_hangman_core: directed and random games checked against a word-level hangman model.
module tb_hangman_core;

  localparam int WL = 5;
  localparam int CW = 8;
  localparam int MT = 7;
  localparam int IW = 6;
`ifdef HANGMAN_REPEAT_PENALTY_EN
  localparam bit PENALTY = 1'b1;
`else
  localparam bit PENALTY = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          guess_valid = 1'b0;
  logic [CW-1:0] guess_char = '0;
  logic          guess_ready;
  logic [IW-1:0] word_idx;
  logic [WL*CW-1:0] word_data = '0;
  logic [WL-1:0] revealed;
  logic [3:0]    tries;
  logic          win, lose, busy;

  int checks = 0;
  int failures = 0;
  int unsigned ecnt = 0;

  logic [7:0]    mword [WL];
  logic [7:0]    alpha [6];
  logic [WL-1:0] mrev = '0;
  int            mtries = 0;
  int            mover = 3;  // 0 playing, 1 won, 2 lost, 3 idle

  hangman_core #(.WORD_LEN(WL), .CHAR_W(CW), .MAX_TRIES(MT), .IDX_W(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_i      (start),
    .guess_valid_i(guess_valid),
    .guess_char_i (guess_char),
    .guess_ready_o(guess_ready),
    .word_idx_o   (word_idx),
    .word_data_i  (word_data),
    .revealed_o   (revealed),
    .tries_o      (tries),
    .win_o        (win),
    .lose_o       (lose),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  // Number of free-running shifts since the last reset edge.
  always @(posedge clk) begin
    if (reset) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_after(input int unsigned n);
    logic [15:0] v;
    v = 16'h0001;
    for (int unsigned i = 0; i < n; i++) v = {v[14:0], ^(v & 16'hB400)};
    return v;
  endfunction

  task automatic set_word(input string s);
    for (int i = 0; i < WL; i++) mword[i] = s[i];
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rev"}, revealed, 0);
    chk({tag, "_tries"}, tries, 0);
    chk({tag, "_win"}, win, 0);
    chk({tag, "_lose"}, lose, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, guess_ready, 0);
    chk({tag, "_idx"}, word_idx, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; start = 1'b0; guess_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    mrev = '0; mtries = 0; mover = 3;
  endtask

  task automatic start_game();
    logic [15:0] exp_l;
    for (int i = 0; i < WL; i++) word_data[i*CW +: CW] = mword[i];
    @(negedge clk);
    start = 1'b1;
    exp_l = lfsr_after(ecnt);
    @(negedge clk);
    start = 1'b0;
    chk("start_idx", word_idx, exp_l[IW-1:0]);
    chk("start_busy", busy, 1);
    @(negedge clk);
    @(negedge clk);
    mrev = '0; mtries = 0; mover = 0;
    chk("start_ready", guess_ready, 1);
    chk("start_rev", revealed, 0);
    chk("start_tries", tries, 0);
    chk("start_win", win, 0);
    chk("start_lose", lose, 0);
    chk("start_busy_end", busy, 0);
  endtask

  task automatic do_guess(input logic [7:0] c);
    logic [WL-1:0] matched;
    logic [WL-1:0] old_rev;
    int old_tries, lat, bcnt;
    bit miss;
    matched = '0;
    for (int i = 0; i < WL; i++) if (mword[i] == c) matched[i] = 1'b1;
    old_rev = mrev;
    old_tries = mtries;
    miss = PENALTY ? ((matched & ~mrev) == '0) : (matched == '0);
    mrev = mrev | matched;
    if (miss && mtries < MT) mtries++;
    if (&mrev) mover = 1;
    else if (mtries == MT) mover = 2;

    @(negedge clk);
    guess_valid = 1'b1;
    guess_char = c;
    @(posedge clk);
    lat = -1;
    bcnt = 0;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      @(negedge clk);
      guess_valid = 1'b0;
      if (i == WL + 1) begin
        chk("early_rev", revealed, old_rev);
        chk("early_tries", tries, old_tries);
      end
      if (busy) bcnt++;
      else lat = i;
    end
    chk("guess_latency", lat, WL + 2);
    chk("busy_cycles", bcnt, WL + 2);
    chk("guess_rev", revealed, mrev);
    chk("guess_tries", tries, mtries);
    chk("guess_win", win, (mover == 1) ? 1 : 0);
    chk("guess_lose", lose, (mover == 2) ? 1 : 0);
    chk("guess_ready", guess_ready, (mover == 0) ? 1 : 0);
  endtask

  task automatic ignored_guess(input logic [7:0] c);
    int bcnt;
    bcnt = 0;
    @(negedge clk);
    guess_valid = 1'b1;
    guess_char = c;
    repeat (10) begin
      @(negedge clk);
      if (busy) bcnt++;
    end
    guess_valid = 1'b0;
    chk("ignore_busy", bcnt, 0);
    chk("ignore_rev", revealed, mrev);
    chk("ignore_tries", tries, mtries);
    chk("ignore_win", win, (mover == 1) ? 1 : 0);
    chk("ignore_lose", lose, (mover == 2) ? 1 : 0);
    chk("ignore_ready", guess_ready, 0);
  endtask

  initial begin
    int n;
    alpha = '{8'h00, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45};

    do_reset();
    check_idle_outputs("reset");

    set_word("APPLE");
    start_game();
    do_guess("P");
    chk("apple_P_rev", revealed, 5'b00110);
    chk("apple_P_tries", tries, 0);
    do_guess("A");
    do_guess("L");
    do_guess("E");
    chk("apple_win_rev", revealed, 5'b11111);
    chk("apple_win", win, 1);
    chk("apple_win_ready", guess_ready, 0);
    chk("apple_win_lose", lose, 0);
    ignored_guess("Z");

    start_game();
    for (int k = 0; k < 7; k++) begin
      do_guess("Z");
      chk("z_tries", tries, k + 1);
    end
    chk("z_lose", lose, 1);
    ignored_guess("A");

    start_game();
    do_guess("P");
    do_guess("P");
    chk("repeat_P_tries", tries, PENALTY ? 1 : 0);

    // Reset lands on the edge that ends the third CHECK cycle.
    @(negedge clk);
    guess_valid = 1'b1;
    guess_char = "L";
    @(posedge clk);
    @(negedge clk);
    guess_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mrev = '0; mtries = 0; mover = 3;
    check_idle_outputs("midcheck_reset");

    for (int g = 0; g < 6; g++) begin
      for (int i = 0; i < WL; i++) mword[i] = alpha[$urandom_range(0, 4)];
      start_game();
      n = 0;
      while (mover == 0 && n < 30) begin
        do_guess(alpha[$urandom_range(0, 5)]);
        n++;
      end
      if (mover == 0) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
